// File: rtl/issue_pkg.sv
// Shared opcodes, instruction field layout and FSM state encoding for the fetch/issue front end.
package issue_pkg;

  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

endpackage

// File: rtl/instr_issue_unit_if.sv
// Instruction-memory req/ack port and decoder valid/ready issue port of the issue unit.
interface instr_issue_unit_if #(
  parameter int unsigned AW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;

  logic          iss_valid;
  logic          iss_ready;
  logic [3:0]    iss_opcode;
  logic [3:0]    iss_rd;
  logic [3:0]    iss_rs1;
  logic [3:0]    iss_rs2;
  logic [AW-1:0] iss_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output iss_valid, iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_pc,
    input  iss_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  iss_valid, iss_opcode, iss_rd, iss_rs1, iss_rs2, iss_pc,
    output iss_ready
  );
endinterface

// File: rtl/issue_fifo.sv
// Synchronous prefetch FIFO with push/pop/flush; DEPTH must be a power of two.
module issue_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/instr_issue_unit.sv
// Fetch/issue front end: prefetches instruction words, issues split fields, handles JMP and HALT.
// Optional ISSUE_PERF_CNT_EN adds saturating perf_issued / perf_stall counters.
module instr_issue_unit
  import issue_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                halted,
  instr_issue_unit_if.master  bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall
`endif
);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned EW = INSTR_W + AW;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_DRAIN  = DRAIN;
  localparam logic [1:0] S_HALTED = HALTED;

  localparam logic [AW-1:0] PC0 = AW'(RESET_PC);

  logic [1:0]    state_q, state_n;
  logic [AW-1:0] pc_q, pc_n;
  logic [AW-1:0] addr_q, addr_n;
  logic          req_q, req_n;
  logic          discard_q, discard_n;

  logic [EW-1:0] fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ_n;

  instr_t        head_instr;
  logic [AW-1:0] head_pc;
  logic [AW-1:0] jmp_target;
  logic          hs, jmp_hs, halt_hs, redirect;
  logic          ack_ok, push, pop, start_ok;

  assign head_instr = instr_t'(fifo_rdata[EW-1 -: INSTR_W]);
  assign head_pc    = fifo_rdata[AW-1:0];
  assign jmp_target = AW'({head_instr.rs1, head_instr.rs2});

  assign hs       = !fifo_empty && bus.iss_ready;
  assign jmp_hs   = hs && (head_instr.op == OP_JMP);
  assign halt_hs  = hs && (head_instr.op == OP_HALT);
  assign redirect = jmp_hs || halt_hs;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_HALTED));

  // Acks for requests issued before a redirect are consumed but never buffered.
  assign ack_ok = req_q && bus.imem_ack;
  assign pop    = hs && !redirect;
  assign push   = ack_ok && !discard_q && !redirect && (state_q == S_RUN) && (!fifo_full || pop);
  assign occ_n  = redirect ? '0 : CW'(fifo_count + CW'(push) - CW'(pop));

  issue_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({bus.imem_rdata, bus.imem_addr}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State and fetch-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      addr_q    <= addr_n;
      req_q     <= req_n;
      discard_q <= discard_n;
      halted    <= (state_n == S_HALTED);
    end
  end

  // Next-state, PC and request decisions.
  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    addr_n    = addr_q;
    req_n     = req_q;
    discard_n = discard_q;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = PC0;
        end
      end
      S_RUN: begin
        if (halt_hs)     state_n = S_DRAIN;
        else if (jmp_hs) pc_n    = jmp_target;
        else if (push)   pc_n    = pc_q + AW'(1);
      end
      S_DRAIN: begin
        if (fifo_empty && !req_q) state_n = S_HALTED;
      end
      default: state_n = S_IDLE;
    endcase

    if (ack_ok) begin
      req_n     = 1'b0;
      discard_n = 1'b0;
    end else if (redirect && req_q) begin
      discard_n = 1'b1;
    end

    // One request in flight at most, and only while a buffer slot is guaranteed for it.
    if (!req_n && (state_n == S_RUN) && (occ_n < CW'(BUF_DEPTH))) begin
      req_n  = 1'b1;
      addr_n = pc_n;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.iss_valid  = !fifo_empty;
  assign bus.iss_opcode = fifo_empty ? 4'h0 : head_instr.op;
  assign bus.iss_rd     = fifo_empty ? 4'h0 : head_instr.rd;
  assign bus.iss_rs1    = fifo_empty ? 4'h0 : head_instr.rs1;
  assign bus.iss_rs2    = fifo_empty ? 4'h0 : head_instr.rs2;
  assign bus.iss_pc     = fifo_empty ? '0   : head_pc;

`ifdef ISSUE_PERF_CNT_EN
  // Saturating issue and stall counters, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (start_ok) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (hs && (perf_issued != '1)) perf_issued <= perf_issued + 32'd1;
      if (!fifo_empty && !bus.iss_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed self-checking bench for instr_issue_unit: in-order issue, backpressure, JMP, HALT,
// PC wrap and asynchronous reset mid-request (perf counters checked when ISSUE_PERF_CNT_EN set).
module tb_instr_issue_unit;
  localparam int unsigned AW        = 8;
  localparam int unsigned BUF_DEPTH = 2;

  logic clk;
  logic rst_n;
  logic start;
  logic halted;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  instr_issue_unit_if #(.AW(AW)) bus ();

  instr_issue_unit #(
    .AW        (AW),
    .BUF_DEPTH (BUF_DEPTH),
    .RESET_PC  (0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .halted (halted),
    .bus    (bus)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]   mem [256];
  int unsigned   lat;
  logic          resp_en;
  logic          late_ack;
  logic [15:0]   iss_word_log [$];
  logic [AW-1:0] iss_pc_log [$];
  logic [AW-1:0] fetch_log [$];
  int unsigned   n_checks;
  int unsigned   n_fail;
  int            bi, bf, nf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int max);
    int i;
    i = 0;
    while (!halted && i < max) begin
      @(posedge clk);
      i++;
    end
    #1;
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic check_issue(input string tag, input int idx, input logic [15:0] w, input logic [AW-1:0] pc);
    if (idx < iss_word_log.size()) begin
      check({tag, "_word"}, 32'(iss_word_log[idx]), 32'(w));
      check({tag, "_pc"},   32'(iss_pc_log[idx]),   32'(pc));
    end else begin
      check({tag, "_missing"}, 32'(iss_word_log.size()), 32'(idx + 1));
    end
  endtask

  // Memory responder: acks a held request after 'lat' extra cycles.
  initial begin
    int unsigned cnt;
    cnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      if (late_ack) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'h1234;
      end else if (resp_en && bus.imem_req) begin
        if (cnt >= lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.iss_valid && bus.iss_ready) begin
        iss_word_log.push_back({bus.iss_opcode, bus.iss_rd, bus.iss_rs1, bus.iss_rs2});
        iss_pc_log.push_back(bus.iss_pc);
      end
      if (bus.imem_req && bus.imem_ack) fetch_log.push_back(bus.imem_addr);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    resp_en  = 1'b1;
    late_ack = 1'b0;
    lat      = 1;
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;

    // Reset values
    #12;
    check("rst_req",    32'(bus.imem_req),   32'd0);
    check("rst_addr",   32'(bus.imem_addr),  32'd0);
    check("rst_valid",  32'(bus.iss_valid),  32'd0);
    check("rst_opcode", 32'(bus.iss_opcode), 32'd0);
    check("rst_rd",     32'(bus.iss_rd),     32'd0);
    check("rst_rs1",    32'(bus.iss_rs1),    32'd0);
    check("rst_rs2",    32'(bus.iss_rs2),    32'd0);
    check("rst_pc",     32'(bus.iss_pc),     32'd0);
    check("rst_halted", 32'(halted),         32'd0);
`ifdef ISSUE_PERF_CNT_EN
    check("rst_perf_issued", perf_issued, 32'd0);
    check("rst_perf_stall",  perf_stall,  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // In-order issue then HALT
    mem[0] = 16'h1123; mem[1] = 16'h1456; mem[2] = 16'hF000; mem[3] = 16'h9999;
    bus.iss_ready = 1'b1;
    bi = iss_word_log.size();
    pulse_start();
    wait_halted("a_halted", 100);
    check("a_count", 32'(iss_word_log.size() - bi), 32'd3);
    check_issue("a_i0", bi,     16'h1123, 8'h00);
    check_issue("a_i1", bi + 1, 16'h1456, 8'h01);
    check_issue("a_i2", bi + 2, 16'hF000, 8'h02);
    if (iss_word_log.size() >= bi + 2) begin
      check("a_op0", 32'(iss_word_log[bi][15:12]),    32'd1);
      check("a_rd0", 32'(iss_word_log[bi][11:8]),     32'd1);
      check("a_rd1", 32'(iss_word_log[bi + 1][11:8]), 32'd4);
    end
    nf = fetch_log.size();
    cycles(6);
    #1;
    check("a_no_fetch", 32'(fetch_log.size()), 32'(nf));
    check("a_req_low",  32'(bus.imem_req),     32'd0);

    // Backpressure, then JMP with a request outstanding
    mem[0] = 16'h2001; mem[1] = 16'h3002; mem[2] = 16'h5003; mem[3] = 16'hE020;
    mem[4] = 16'h7777; mem[8'h20] = 16'hF000;
    bus.iss_ready = 1'b0;
    lat = 1;
    bi = iss_word_log.size();
    bf = fetch_log.size();
    pulse_start();
    check("b_halted_clr", 32'(halted), 32'd0);
    cycles(10);
    #1;
    check("b_fetched",  32'(fetch_log.size() - bf), 32'(BUF_DEPTH));
    check("b_req_low",  32'(bus.imem_req),  32'd0);
    check("b_valid",    32'(bus.iss_valid), 32'd1);
    check("b_head_pc",  32'(bus.iss_pc),    32'd0);
    check("b_head_op",  32'(bus.iss_opcode), 32'd2);
    if (fetch_log.size() > bf) check("b_first_addr", 32'(fetch_log[bf]), 32'd0);
    lat = 6;
    bus.iss_ready = 1'b1;
    wait_halted("b_halted", 300);
    check("b_count", 32'(iss_word_log.size() - bi), 32'd5);
    check_issue("b_i0", bi,     16'h2001, 8'h00);
    check_issue("b_i1", bi + 1, 16'h3002, 8'h01);
    check_issue("b_i2", bi + 2, 16'h5003, 8'h02);
    check_issue("b_i3", bi + 3, 16'hE020, 8'h03);
    check_issue("b_i4", bi + 4, 16'hF000, 8'h20);
    if (fetch_log.size() >= bf + 6) begin
      check("b_stale_addr", 32'(fetch_log[bf + 4]), 32'h04);
      check("b_jmp_addr",   32'(fetch_log[bf + 5]), 32'h20);
    end else begin
      check("b_fetch_count", 32'(fetch_log.size() - bf), 32'd6);
    end

    // PC wrap 0xFF -> 0x00
    mem[0] = 16'hE0FE; mem[1] = 16'h1111; mem[8'hFE] = 16'h6ABC; mem[8'hFF] = 16'h7DEF;
    lat = 1;
    bi = iss_word_log.size();
    pulse_start();
    for (int i = 0; i < 50 && iss_word_log.size() == bi; i++) @(posedge clk);
    check("c_jmp_seen", 32'(iss_word_log.size() > bi), 32'd1);
    mem[0] = 16'hF000;
    wait_halted("c_halted", 100);
    check("c_count", 32'(iss_word_log.size() - bi), 32'd4);
    check_issue("c_i0", bi,     16'hE0FE, 8'h00);
    check_issue("c_i1", bi + 1, 16'h6ABC, 8'hFE);
    check_issue("c_i2", bi + 2, 16'h7DEF, 8'hFF);
    check_issue("c_i3", bi + 3, 16'hF000, 8'h00);

    // Asynchronous reset mid-request, then a late ack in IDLE
    mem[0] = 16'h1123; mem[1] = 16'h1456; mem[2] = 16'h1789;
    bus.iss_ready = 1'b0;
    lat = 3;
    pulse_start();
    cycles(5);
    #3;
    check("d_pre_valid", 32'(bus.iss_valid), 32'd1);
    check("d_pre_req",   32'(bus.imem_req),  32'd1);
`ifdef ISSUE_PERF_CNT_EN
    check("d_pre_stall_nz", 32'(perf_stall != 32'd0), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("d_rst_req",    32'(bus.imem_req),   32'd0);
    check("d_rst_valid",  32'(bus.iss_valid),  32'd0);
    check("d_rst_opcode", 32'(bus.iss_opcode), 32'd0);
    check("d_rst_halted", 32'(halted),         32'd0);
`ifdef ISSUE_PERF_CNT_EN
    check("d_rst_perf_issued", perf_issued, 32'd0);
    check("d_rst_perf_stall",  perf_stall,  32'd0);
`endif
    resp_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); late_ack = 1'b1;
    @(negedge clk); late_ack = 1'b0;
    cycles(3);
    #1;
    check("d_late_valid", 32'(bus.iss_valid), 32'd0);
    check("d_late_req",   32'(bus.imem_req),  32'd0);
    check("d_late_halted", 32'(halted),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
